// File: rtl/spram_arbiter.sv
// spram_arbiter: two-port round-robin front end for a single-port RAM, clearing the RAM after reset
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata, a_gnt/a_rvalid  requester A access and grant/read-return flags
//   b_req/b_we/b_addr/b_wdata, b_gnt/b_rvalid  requester B, same meaning as A
//   rdata                 shared read-return data, zero when neither rvalid is set
//   init_done             RAM clear finished, arbitration running
//   ram_we/ram_addr/ram_data  command to the RAM
//   ram_out               registered RAM read data, one cycle after the address
module spram_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 36
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  init_done,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_out
);
    typedef enum logic {INIT, RUN} state_t;
    state_t                state_q;
    logic [ADDR_WIDTH-1:0] clr_cnt_q;
    logic                  last_b_q;
    logic                  a_rvalid_q;
    logic                  b_rvalid_q;
    logic                  run;
    assign run       = state_q == RUN;
    assign init_done = run;
    // on conflict the side that did not win last time gets the RAM
    assign a_gnt     = run & a_req & (~b_req | last_b_q);
    assign b_gnt     = run & b_req & (~a_req | ~last_b_q);
    assign ram_we    = !run ? 1'b1 : a_gnt ? a_we : b_gnt & b_we;
    assign ram_addr  = !run ? clr_cnt_q : a_gnt ? a_addr : b_gnt ? b_addr : '0;
    assign ram_data  = !run ? '0 : a_gnt ? a_wdata : b_gnt ? b_wdata : '0;
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign rdata     = (a_rvalid_q | b_rvalid_q) ? ram_out : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            clr_cnt_q  <= '0;
            last_b_q   <= 1'b1;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            // the counter parks on the last address rather than wrapping
            if (!run) begin
                if (&clr_cnt_q) state_q <= RUN;
                else clr_cnt_q <= clr_cnt_q + 1'b1;
            end
            if (a_gnt | b_gnt) last_b_q <= b_gnt;
            a_rvalid_q <= a_gnt & ~a_we;
            b_rvalid_q <= b_gnt & ~b_we;
        end
    end
endmodule

// File: doc/spram_arbiter.md
SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 11: RAM address width in bits.
REQ-002 Parameter DATA_WIDTH, default 36: RAM word width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 a_req  input  1  requester A access request.
REQ-006 a_we  input  1  requester A write (1) / read (0).
REQ-007 a_addr  input  ADDR_WIDTH  requester A word address.
REQ-008 a_wdata  input  DATA_WIDTH  requester A write data.
REQ-009 a_gnt  output  1  requester A access accepted this cycle.
REQ-010 a_rvalid  output  1  read data for requester A valid on rdata.
REQ-011 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid: same widths and meanings as REQ-005 to REQ-010, for requester B.
REQ-012 rdata  output  DATA_WIDTH  shared read-return data.
REQ-013 init_done  output  1  memory clear complete; arbitration active.
REQ-014 ram_we  output  1  write enable to the single_port_ram instance.
REQ-015 ram_addr  output  ADDR_WIDTH  address to the RAM.
REQ-016 ram_data  output  DATA_WIDTH  write data to the RAM.
REQ-017 ram_out  input  DATA_WIDTH  registered RAM output; valid one cycle after the address is presented.

Function
REQ-018 The FSM SHALL have two states: INIT and RUN.
REQ-019 In INIT, the block SHALL drive ram_we=1, ram_data=0 and ram_addr=clr_cnt, and SHALL increment clr_cnt by 1 each cycle.
REQ-020 In INIT, when clr_cnt equals 2^ADDR_WIDTH-1, the block SHALL perform that write and enter RUN on the next edge; a full clear SHALL take exactly 2^ADDR_WIDTH cycles.
REQ-021 init_done SHALL be 1 if and only if the state is RUN.
REQ-022 In INIT, a_gnt and b_gnt SHALL be 0 regardless of a_req and b_req.
REQ-023 In RUN, a_gnt and b_gnt SHALL be combinational from the current inputs, and at most one SHALL be 1 per cycle.
REQ-024 In RUN, a sole requester SHALL be granted in the same cycle it requests.
REQ-025 In RUN, when both requesters request, the requester not granted most recently SHALL be granted, using a 1-bit round-robin pointer last_b.
REQ-026 last_b SHALL update only on cycles with a grant: 1 after a B grant, 0 after an A grant.
REQ-027 On a grant, ram_we, ram_addr and ram_data SHALL equal the granted requester's we, addr and wdata.
REQ-028 In RUN, with no grant, ram_we SHALL be 0 and ram_addr and ram_data SHALL be 0.
REQ-029 A requester SHALL hold req, we, addr and wdata stable until it sees gnt=1; the transfer completes at the rising edge where gnt=1.
REQ-030 A granted read SHALL assert the matching x_rvalid for exactly one cycle, on the cycle after the grant, with rdata = ram_out in that cycle.
REQ-031 A granted write SHALL produce no rvalid.
REQ-032 When no rvalid is asserted, rdata SHALL be 0.
REQ-033 Back-to-back grants SHALL be sustained: one access per cycle, with reads pipelined one cycle behind their grants.
REQ-034 A read to an address written on the previous cycle SHALL return the newly written data.
REQ-035 An address at 2^ADDR_WIDTH-1 SHALL be legal; clr_cnt SHALL NOT wrap to 0 while in INIT.

Reset
REQ-036 While rst_n=0, the block SHALL hold state=INIT, clr_cnt=0, last_b=1 (so A wins the first conflict), a_rvalid=0, b_rvalid=0 and init_done=0.
REQ-037 Asserting rst_n mid-operation SHALL immediately abort any pending read return and set both rvalid outputs to 0.
REQ-038 After rst_n deasserts following a mid-operation reset, the clear SHALL restart from address 0.

Verification
REQ-039 Release reset with both req=1 -> no grant for 2^ADDR_WIDTH cycles, ram_we=1 with addresses 0..2047, init_done rises on cycle 2048, then a_gnt=1 first.
REQ-040 After init, A reads addr 5 -> a_gnt=1 in cycle N, a_rvalid=1 with rdata=0 in cycle N+1, b_rvalid=0.
REQ-041 Both requesters request continuously: A writes addr 3 with 36'h123456789, B reads addr 3 -> grants alternate A,B,A,B; B's rvalid returns 36'h123456789.
REQ-042 Only B requests for 4 cycles -> b_gnt=1 in all 4 cycles; a following conflict grants A.
REQ-043 A read is granted, then rst_n is pulsed low before the return cycle -> a_rvalid stays 0, init_done=0, and the clear restarts at address 0.
REQ-044 A writes addr 2047 and then reads it back -> rdata equals the written value, with no address wrap.
